muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Multi-cycle multiply/divide unit that owns the architectural HI and LO registers for the MIPS datapath. Decode launches MULT, MULTU, DIV and DIVU here with a start handshake. The ALU's MFHI/MFLO path then reads the results from this block's HI/LO outputs. Opcode values come from the shared `isa_codes.v` SPECIAL_* definitions.

## Interface
- WIDTH, 32, operand, HI and LO width.
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- w_start  in  1  launch request; sampled only in IDLE.
- w_op_code_6  in  6  SPECIAL_MULT / SPECIAL_MULTU / SPECIAL_DIV / SPECIAL_DIVU; sampled with w_start.
- w_rs_x  in  WIDTH  multiplicand / dividend.
- w_rt_x  in  WIDTH  multiplier / divisor.
- w_write_hi  in  1  MTHI: load w_rs_x into HI.
- w_write_lo  in  1  MTLO: load w_rs_x into LO.
- w_busy  out  1  high while an operation is in flight.
- w_done  out  1  one-cycle pulse when HI/LO holds a new result.
- w_div_by_zero  out  1  qualifies w_done; divisor was zero.
- w_hi_x  out  WIDTH  HI register.
- w_lo_x  out  WIDTH  LO register.

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE, w_start=1, opcode one of the four listed:
  - Latch operand magnitudes.
  - Signed ops take the two's-complement absolute value.
  - Record the result sign(s) and the op type.
  - Load the iteration counter with WIDTH.
  - Go to CALC.
- IDLE, w_start=1, any other opcode: ignored; no state change.
- CALC: one iteration per cycle; counter decrements; after the WIDTH-th iteration go to FIXUP.
  - Multiply: shift-add, 1 multiplier bit per cycle, into a 2*WIDTH product register.
  - Divide: restoring, 1 quotient bit per cycle; the partial remainder is WIDTH+1 bits.
- FIXUP:
  - Apply signs. Product is negated if operand signs differ. Quotient is negated if operand signs differ. Remainder takes the dividend's sign.
  - Write HI/LO. Multiply: HI=product[2W-1:W], LO=product[W-1:0]. Divide: LO=quotient, HI=remainder.
  - Go to IDLE.
- Divide by zero (DIV/DIVU with w_rt_x=0, detected in IDLE): skip CALC; HI/LO unchanged; w_done=1 and w_div_by_zero=1 on the next cycle.
- DIV of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- w_write_hi / w_write_lo: honoured only in IDLE; ignored while busy.
  - Both asserted: both registers load w_rs_x.
  - Asserted in the same cycle as an accepted w_start: the write applies at that edge; the operation result later overwrites it.
- w_start while busy: ignored; not queued.

## Timing
- Reset values: state=IDLE, w_hi_x=0, w_lo_x=0, w_busy=0, w_done=0, w_div_by_zero=0. Reset overrides all other inputs.
- Reset mid-operation: the in-flight op is discarded; no w_done.
- Start accepted at edge E0:
  - w_busy=1 from after E0 until after E(WIDTH+1).
  - Iterations occur at edges E1..E(WIDTH).
  - FIXUP writes HI/LO at E(WIDTH+1).
- After E(WIDTH+1): w_done=1 for exactly one cycle, w_busy=0, new HI/LO visible. Latency is 33 cycles for WIDTH=32.
- A new w_start can be accepted in the same cycle w_done is high (back-to-back).
- Divide by zero: after E0, w_busy stays 0; w_done=w_div_by_zero=1 for one cycle.
- w_div_by_zero is 0 whenever w_done is 0.
- HI/LO outputs are registered and change only at FIXUP, at an MTHI/MTLO edge, or at reset.

## Test plan
- MULT 7 × 0xFFFFFFFD (−3) -> after 33 cycles: w_done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFEB; w_busy high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Back-to-back DIVU 100/7 started on the done cycle -> LO=14, HI=2 after a further 33 cycles.
- DIV 0xFFFFFFF9 (−7) / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Preload HI=0x1234, LO=0x5678 via MTHI/MTLO, then DIVU 5/0 -> w_done and w_div_by_zero high one cycle after start; HI/LO unchanged; w_busy never asserted.
- During MULT 3×4:
  - Cycle 10: pulse w_start with DIVU, and w_write_hi=1 with w_rs_x=0xDEAD -> both ignored; result HI=0, LO=12.
  - Cycle 20 of a second op: assert reset -> HI=LO=0, w_busy=0, no w_done.
- w_start with opcode SPECIAL_ADD -> no state change; w_busy stays 0.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if
// Groups the decode-side launch/MT* controls and the HI/LO result
// signals of the multiply/divide unit into one bundle.
//
// Signals
//   w_start        launch request (sampled only while the unit is idle)
//   w_op_code_6    SPECIAL_MULT / SPECIAL_MULTU / SPECIAL_DIV / SPECIAL_DIVU
//   w_rs_x         multiplicand / dividend, also the MTHI/MTLO data
//   w_rt_x         multiplier / divisor
//   w_write_hi     MTHI: load w_rs_x into HI
//   w_write_lo     MTLO: load w_rs_x into LO
//   w_busy         operation in flight
//   w_done         one-cycle pulse when HI/LO holds a new result
//   w_div_by_zero  qualifies w_done; divisor was zero
//   w_hi_x         HI register
//   w_lo_x         LO register
//
// Modports: master = decode/datapath side, slave = muldiv_unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             w_start;
  logic [5:0]       w_op_code_6;
  logic [WIDTH-1:0] w_rs_x;
  logic [WIDTH-1:0] w_rt_x;
  logic             w_write_hi;
  logic             w_write_lo;
  logic             w_busy;
  logic             w_done;
  logic             w_div_by_zero;
  logic [WIDTH-1:0] w_hi_x;
  logic [WIDTH-1:0] w_lo_x;

  modport master (
    output w_start, w_op_code_6, w_rs_x, w_rt_x, w_write_hi, w_write_lo,
    input  w_busy, w_done, w_div_by_zero, w_hi_x, w_lo_x
  );

  modport slave (
    input  w_start, w_op_code_6, w_rs_x, w_rt_x, w_write_hi, w_write_lo,
    output w_busy, w_done, w_div_by_zero, w_hi_x, w_lo_x
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit
// Multi-cycle multiply/divide unit owning the architectural HI and LO
// registers. MULT/MULTU use a shift-add multiplier, DIV/DIVU a restoring
// divider; both retire one bit per cycle on operand magnitudes, and the
// signs are applied in a final FIXUP cycle. A launch takes WIDTH+1 cycles
// from the accepting edge to the done pulse.
//
// Ports
//   clock  system clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    muldiv_unit_if.slave (launch, MTHI/MTLO, busy/done, HI/LO)
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  muldiv_unit_if.slave bus
);

  // Funct codes mirrored from the shared ISA definitions.
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } state_t;

  state_t state;
  state_t next_state;

  logic [CW-1:0]      count;
  logic               is_div;
  logic               sign_neg;
  logic               rem_neg;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               done;
  logic               dbz;

  logic               op_valid;
  logic               op_div;
  logic               op_signed;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic               rt_zero;
  logic               accept;
  logic               div_zero_hit;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Launch decode: classify the opcode and form operand magnitudes. A
  // divide by zero never enters CALC; it only produces the flagged done.
  always_comb begin
    op_valid     = (bus.w_op_code_6 == SPECIAL_MULT) || (bus.w_op_code_6 == SPECIAL_MULTU) ||
                   (bus.w_op_code_6 == SPECIAL_DIV)  || (bus.w_op_code_6 == SPECIAL_DIVU);
    op_div       = (bus.w_op_code_6 == SPECIAL_DIV)  || (bus.w_op_code_6 == SPECIAL_DIVU);
    op_signed    = (bus.w_op_code_6 == SPECIAL_MULT) || (bus.w_op_code_6 == SPECIAL_DIV);
    rs_neg       = op_signed && bus.w_rs_x[WIDTH-1];
    rt_neg       = op_signed && bus.w_rt_x[WIDTH-1];
    rs_mag       = rs_neg ? -bus.w_rs_x : bus.w_rs_x;
    rt_mag       = rt_neg ? -bus.w_rt_x : bus.w_rt_x;
    rt_zero      = (bus.w_rt_x == '0);
    accept       = (state == IDLE) && bus.w_start && op_valid && !(op_div && rt_zero);
    div_zero_hit = (state == IDLE) && bus.w_start && op_div && rt_zero;
  end

  // One iteration of each algorithm. The multiplier adds the multiplicand
  // into the upper half when the current multiplier bit (prod[0]) is set,
  // then shifts right. The divider shifts the next dividend bit (top of
  // the low half) into the partial remainder and keeps the subtraction
  // only if it did not go negative. Magnitudes always fit, so the
  // most negative value needs no special handling.
  always_comb begin
    mul_sum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    div_shift = {rem, prod[WIDTH-1]};
    div_trial = div_shift - {1'b0, mcand};
    prod_fix  = sign_neg ? -prod : prod;
    quo_fix   = sign_neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
    rem_fix   = rem_neg ? -rem : rem;
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: WIDTH iterations in CALC, then one FIXUP cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = CALC;
      CALC:    if (count == CW'(1)) next_state = FIXUP;
      FIXUP:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and HI/LO. MTHI/MTLO are honoured only in IDLE, including the
  // edge that accepts a launch; the launched op overwrites them later.
  always_ff @(posedge clock) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      dbz      <= 1'b0;
      count    <= '0;
      prod     <= '0;
      rem      <= '0;
      mcand    <= '0;
      is_div   <= 1'b0;
      sign_neg <= 1'b0;
      rem_neg  <= 1'b0;
    end else begin
      done <= 1'b0;
      dbz  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.w_write_hi) hi <= bus.w_rs_x;
          if (bus.w_write_lo) lo <= bus.w_rs_x;
          if (accept) begin
            count    <= CW'(WIDTH);
            is_div   <= op_div;
            sign_neg <= rs_neg ^ rt_neg;
            rem_neg  <= rs_neg;
            rem      <= '0;
            if (op_div) begin
              mcand <= rt_mag;
              prod  <= {{WIDTH{1'b0}}, rs_mag};
            end else begin
              mcand <= rs_mag;
              prod  <= {{WIDTH{1'b0}}, rt_mag};
            end
          end else if (div_zero_hit) begin
            done <= 1'b1;
            dbz  <= 1'b1;
          end
        end
        CALC: begin
          count <= count - 1'b1;
          if (is_div) begin
            if (!div_trial[WIDTH]) begin
              rem              <= div_trial[WIDTH-1:0];
              prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b1};
            end else begin
              rem              <= div_shift[WIDTH-1:0];
              prod[WIDTH-1:0]  <= {prod[WIDTH-2:0], 1'b0};
            end
          end else begin
            prod <= {mul_sum, prod[WIDTH-1:1]};
          end
        end
        FIXUP: begin
          if (is_div) begin
            lo <= quo_fix;
            hi <= rem_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.w_busy        = (state != IDLE);
  assign bus.w_done        = done;
  assign bus.w_div_by_zero = dbz;
  assign bus.w_hi_x        = hi;
  assign bus.w_lo_x        = lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit
// Table-driven bench for muldiv_unit plus hand-written sequences for
// back-to-back launch, divide by zero, MTHI/MTLO interaction, ignored
// starts and reset in the middle of an operation.
module tb_muldiv_unit;

  localparam int WIDTH = 32;
  localparam logic [5:0] SPECIAL_MULT  = 6'h18;
  localparam logic [5:0] SPECIAL_MULTU = 6'h19;
  localparam logic [5:0] SPECIAL_DIV   = 6'h1A;
  localparam logic [5:0] SPECIAL_DIVU  = 6'h1B;
  localparam logic [5:0] SPECIAL_ADD   = 6'h20;
  localparam int LAT_WAIT = 34;
  localparam int BUSY_LEN = 33;
  localparam int NVEC     = 11;

  typedef struct {
    logic [5:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs [NVEC];

  muldiv_unit_if #(.WIDTH(WIDTH)) bus ();

  muldiv_unit #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  // Present a launch on the bus; called right after a falling edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt);
    bus.w_start     = 1'b1;
    bus.w_op_code_6 = op;
    bus.w_rs_x      = rs;
    bus.w_rt_x      = rt;
  endtask

  // Step falling edges until w_done is seen or the limit expires. Optional
  // interference: at cycle inject_at a DIVU start with MTHI 0xDEAD, at
  // cycle reset_at a one-cycle reset.
  task automatic wait_done(input int inject_at, input int reset_at, input int limit,
                           output int done_wait, output int busy_cycles, output logic dbz_seen);
    done_wait   = 0;
    busy_cycles = 0;
    dbz_seen    = 1'b0;
    while (done_wait < limit) begin
      @(negedge clock);
      done_wait++;
      bus.w_start    = 1'b0;
      bus.w_write_hi = 1'b0;
      bus.w_write_lo = 1'b0;
      reset          = 1'b0;
      if (done_wait == inject_at) begin
        bus.w_start     = 1'b1;
        bus.w_op_code_6 = SPECIAL_DIVU;
        bus.w_rs_x      = 32'h0000DEAD;
        bus.w_rt_x      = 32'd1;
        bus.w_write_hi  = 1'b1;
      end
      if (done_wait == reset_at) reset = 1'b1;
      if (bus.w_busy) busy_cycles++;
      if (bus.w_done) begin
        dbz_seen = bus.w_div_by_zero;
        break;
      end
    end
  endtask

  initial begin
    int          dw;
    int          bc;
    logic        dz;
    int          seen_busy;
    int          seen_done;

    checks = 0;
    errors = 0;

    vecs[0]  = '{SPECIAL_MULT,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
    vecs[1]  = '{SPECIAL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[2]  = '{SPECIAL_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
    vecs[3]  = '{SPECIAL_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[4]  = '{SPECIAL_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
    vecs[5]  = '{SPECIAL_MULT,  32'd3,        32'd4,        32'd0,        32'd12,       1'b0};
    vecs[6]  = '{SPECIAL_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[7]  = '{SPECIAL_MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0,        1'b0};
    vecs[8]  = '{SPECIAL_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,        1'b0};
    vecs[9]  = '{SPECIAL_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[10] = '{SPECIAL_DIVU,  32'd5,        32'd0,        32'd0,        32'hFFFFFFFF, 1'b1};

    bus.w_start     = 1'b0;
    bus.w_op_code_6 = 6'd0;
    bus.w_rs_x      = '0;
    bus.w_rt_x      = '0;
    bus.w_write_hi  = 1'b0;
    bus.w_write_lo  = 1'b0;
    reset           = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    $display("[TB] reset state");
    checkOutput("reset_hi",   bus.w_hi_x, 32'd0);
    checkOutput("reset_lo",   bus.w_lo_x, 32'd0);
    checkOutput("reset_busy", 32'(bus.w_busy), 32'd0);
    checkOutput("reset_done", 32'(bus.w_done), 32'd0);
    checkOutput("reset_dbz",  32'(bus.w_div_by_zero), 32'd0);

    $display("[TB] vector table");
    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i].op, vecs[i].rs, vecs[i].rt);
      wait_done(0, 0, 100, dw, bc, dz);
      checkOutput($sformatf("v%0d_wait", i), 32'(dw), vecs[i].dbz ? 32'd1 : 32'(LAT_WAIT));
      checkOutput($sformatf("v%0d_busy", i), 32'(bc), vecs[i].dbz ? 32'd0 : 32'(BUSY_LEN));
      checkOutput($sformatf("v%0d_dbz", i),  32'(dz), 32'(vecs[i].dbz));
      checkOutput($sformatf("v%0d_hi", i),   bus.w_hi_x, vecs[i].hi);
      checkOutput($sformatf("v%0d_lo", i),   bus.w_lo_x, vecs[i].lo);
      @(negedge clock);
      checkOutput($sformatf("v%0d_done_pulse", i), 32'(bus.w_done), 32'd0);
      checkOutput($sformatf("v%0d_dbz_low", i),    32'(bus.w_div_by_zero), 32'd0);
    end

    $display("[TB] back-to-back launch on done cycle");
    applyStimulus(SPECIAL_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(0, 0, 100, dw, bc, dz);
    checkOutput("b2b_first_wait", 32'(dw), 32'(LAT_WAIT));
    checkOutput("b2b_first_hi", bus.w_hi_x, 32'hFFFFFFFE);
    checkOutput("b2b_first_lo", bus.w_lo_x, 32'h00000001);
    applyStimulus(SPECIAL_DIVU, 32'd100, 32'd7);
    wait_done(0, 0, 100, dw, bc, dz);
    checkOutput("b2b_second_wait", 32'(dw), 32'(LAT_WAIT));
    checkOutput("b2b_second_hi", bus.w_hi_x, 32'd2);
    checkOutput("b2b_second_lo", bus.w_lo_x, 32'd14);
    @(negedge clock);

    $display("[TB] MTHI/MTLO preload then divide by zero");
    bus.w_write_hi = 1'b1;
    bus.w_rs_x     = 32'h00001234;
    @(negedge clock);
    bus.w_write_hi = 1'b0;
    bus.w_write_lo = 1'b1;
    bus.w_rs_x     = 32'h00005678;
    @(negedge clock);
    bus.w_write_lo = 1'b0;
    checkOutput("mt_hi", bus.w_hi_x, 32'h00001234);
    checkOutput("mt_lo", bus.w_lo_x, 32'h00005678);
    applyStimulus(SPECIAL_DIVU, 32'd5, 32'd0);
    wait_done(0, 0, 100, dw, bc, dz);
    checkOutput("dz_wait", 32'(dw), 32'd1);
    checkOutput("dz_busy", 32'(bc), 32'd0);
    checkOutput("dz_flag", 32'(dz), 32'd1);
    checkOutput("dz_hi", bus.w_hi_x, 32'h00001234);
    checkOutput("dz_lo", bus.w_lo_x, 32'h00005678);
    @(negedge clock);
    checkOutput("dz_done_pulse", 32'(bus.w_done), 32'd0);
    checkOutput("dz_flag_low", 32'(bus.w_div_by_zero), 32'd0);

    $display("[TB] MTHI and MTLO together");
    bus.w_write_hi = 1'b1;
    bus.w_write_lo = 1'b1;
    bus.w_rs_x     = 32'hABCD0123;
    @(negedge clock);
    bus.w_write_hi = 1'b0;
    bus.w_write_lo = 1'b0;
    checkOutput("mt_both_hi", bus.w_hi_x, 32'hABCD0123);
    checkOutput("mt_both_lo", bus.w_lo_x, 32'hABCD0123);

    $display("[TB] start with non-muldiv opcode");
    applyStimulus(SPECIAL_ADD, 32'd1, 32'd1);
    seen_busy = 0;
    seen_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      bus.w_start = 1'b0;
      if (bus.w_busy) seen_busy++;
      if (bus.w_done) seen_done++;
    end
    checkOutput("add_busy", 32'(seen_busy), 32'd0);
    checkOutput("add_done", 32'(seen_done), 32'd0);
    checkOutput("add_hi", bus.w_hi_x, 32'hABCD0123);
    checkOutput("add_lo", bus.w_lo_x, 32'hABCD0123);

    $display("[TB] MTHI on the accepting edge");
    applyStimulus(SPECIAL_MULT, 32'd3, 32'd4);
    bus.w_write_hi = 1'b1;
    @(negedge clock);
    bus.w_start    = 1'b0;
    bus.w_write_hi = 1'b0;
    checkOutput("mt_start_hi", bus.w_hi_x, 32'd3);
    checkOutput("mt_start_busy", 32'(bus.w_busy), 32'd1);
    wait_done(0, 0, 100, dw, bc, dz);
    checkOutput("mt_start_wait", 32'(dw), 32'(LAT_WAIT - 1));
    checkOutput("mt_start_res_hi", bus.w_hi_x, 32'd0);
    checkOutput("mt_start_res_lo", bus.w_lo_x, 32'd12);
    @(negedge clock);

    $display("[TB] start and MTHI while busy");
    applyStimulus(SPECIAL_MULT, 32'd3, 32'd4);
    wait_done(10, 0, 100, dw, bc, dz);
    checkOutput("busy_ign_wait", 32'(dw), 32'(LAT_WAIT));
    checkOutput("busy_ign_busy", 32'(bc), 32'(BUSY_LEN));
    checkOutput("busy_ign_hi", bus.w_hi_x, 32'd0);
    checkOutput("busy_ign_lo", bus.w_lo_x, 32'd12);
    @(negedge clock);
    checkOutput("busy_ign_no_requeue", 32'(bus.w_busy), 32'd0);

    $display("[TB] reset in the middle of an operation");
    bus.w_write_hi = 1'b1;
    bus.w_write_lo = 1'b1;
    bus.w_rs_x     = 32'h00000055;
    @(negedge clock);
    bus.w_write_hi = 1'b0;
    bus.w_write_lo = 1'b0;
    checkOutput("pre_rst_hi", bus.w_hi_x, 32'h00000055);
    applyStimulus(SPECIAL_MULT, 32'd3, 32'd4);
    wait_done(0, 20, 60, dw, bc, dz);
    checkOutput("rst_mid_no_done", 32'(dw), 32'd60);
    checkOutput("rst_mid_busy_cycles", 32'(bc), 32'd20);
    checkOutput("rst_mid_busy", 32'(bus.w_busy), 32'd0);
    checkOutput("rst_mid_hi", bus.w_hi_x, 32'd0);
    checkOutput("rst_mid_lo", bus.w_lo_x, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Backstop against a hung run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
